// File: rtl/demux16_router.sv
// demux16_router: steers one source word stream to channel A or B.
// The select bit travels with each word. Each channel holds one word in a
// registered output stage with a valid/ready handshake, so a stalled channel
// back-pressures only the source words that are aimed at it.

// One-entry output stage with a drain+load path and a delivered-word counter.
module demux16_router_chan #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             free,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  logic fire;

  // The stage can take a word when it is empty, or when its word leaves this cycle.
  assign free = !valid || ready;
  assign fire = valid && ready;

  // A load always wins over a drain, which keeps the stage full back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

  // Data changes only on a load. A drained word is kept, with valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  // Count words actually taken by the consumer. The counter wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (fire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

module demux16_router #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  logic a_free;
  logic b_free;
  logic acc;
  logic a_load;
  logic b_load;

  // in_ready looks only at the addressed channel, never at in_valid.
  assign in_ready = in_sel ? b_free : a_free;
  assign acc      = in_valid && in_ready;
  assign a_load   = acc && !in_sel;
  assign b_load   = acc &&  in_sel;

  demux16_router_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (a_load),
    .load_data (in_data),
    .free      (a_free),
    .valid     (a_valid),
    .ready     (a_ready),
    .data      (a_data),
    .count     (a_count)
  );

  demux16_router_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (b_load),
    .load_data (in_data),
    .free      (b_free),
    .valid     (b_valid),
    .ready     (b_ready),
    .data      (b_data),
    .count     (b_count)
  );

endmodule

// File: tb/tb_demux16_router.sv
// Bench for demux16_router: directed stimulus feeding a per-channel
// expected-word queue, with a monitor that checks every output handshake.
module tb_demux16_router;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_sel;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] b_data;
  logic [7:0]  a_count;
  logic [7:0]  b_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  exp_a_cnt;
  logic [7:0]  exp_b_cnt;

  demux16_router #(.WIDTH(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at a falling edge completes at the next rising edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      exp_a_cnt = 8'd0;
      exp_b_cnt = 8'd0;
    end else begin
      if (a_valid && a_ready) begin
        if (qa.size() == 0) check("a_unexpected_word", {16'd0, a_data}, 32'hFFFF_FFFF);
        else check("a_word", {16'd0, a_data}, {16'd0, qa.pop_front()});
        check("a_count_at_hs", {24'd0, a_count}, {24'd0, exp_a_cnt});
        exp_a_cnt = exp_a_cnt + 8'd1;
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) check("b_unexpected_word", {16'd0, b_data}, 32'hFFFF_FFFF);
        else check("b_word", {16'd0, b_data}, {16'd0, qb.pop_front()});
        check("b_count_at_hs", {24'd0, b_count}, {24'd0, exp_b_cnt});
        exp_b_cnt = exp_b_cnt + 8'd1;
      end
    end
  end

  // Inputs are driven 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted; returns 1 unit after the accepting edge.
  task automatic send(input logic sel, input logic [15:0] data);
    logic r;
    logic ok;
    ok = 1'b0;
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    if (sel) qb.push_back(data);
    else     qa.push_back(data);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  // Async reset pulse between edges, checked before any clock edge.
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    check("rst_a_data",  {16'd0, a_data},  32'd0);
    check("rst_b_data",  {16'd0, b_data},  32'd0);
    check("rst_a_count", {24'd0, a_count}, 32'd0);
    check("rst_b_count", {24'd0, b_count}, 32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 16'd0;
    in_sel = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    #3;
    check("init_a_valid", {31'd0, a_valid}, 32'd0);
    check("init_b_valid", {31'd0, b_valid}, 32'd0);
    check("init_a_count", {24'd0, a_count}, 32'd0);
    check("init_b_count", {24'd0, b_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset while A holds a word.
    send(1'b0, 16'd63);
    check("hold_a_valid", {31'd0, a_valid}, 32'd1);
    check("hold_a_data",  {16'd0, a_data},  32'd63);
    reset_pulse();
    tick();

    // Basic steering with both consumers ready.
    a_ready = 1'b1;
    b_ready = 1'b1;
    send(1'b0, 16'd63);
    check("steer_a_data", {16'd0, a_data}, 32'd63);
    check("steer_a_valid", {31'd0, a_valid}, 32'd1);
    send(1'b1, 16'd24);
    check("steer_b_data", {16'd0, b_data}, 32'd24);
    check("steer_b_valid", {31'd0, b_valid}, 32'd1);
    check("steer_a_drained", {31'd0, a_valid}, 32'd0);
    tick();
    tick();
    check("steer_a_count", {24'd0, a_count}, 32'd1);
    check("steer_b_count", {24'd0, b_count}, 32'd1);

    // Back-pressure on B.
    b_ready = 1'b0;
    send(1'b1, 16'd31);
    check("bp_b_data", {16'd0, b_data}, 32'd31);
    in_sel = 1'b1;
    in_data = 16'd127;
    in_valid = 1'b1;
    qb.push_back(16'd127);
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    @(negedge clk);
    check("bp_b_held", {16'd0, b_data}, 32'd31);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    tick();
    b_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_b_valid", {31'd0, b_valid}, 32'd1);
    check("bp_b_data_new", {16'd0, b_data}, 32'd127);
    check("bp_b_count1", {24'd0, b_count}, 32'd2);
    tick();
    check("bp_b_count2", {24'd0, b_count}, 32'd3);
    check("bp_b_empty", {31'd0, b_valid}, 32'd0);

    // A word for A passes while B is stalled.
    b_ready = 1'b0;
    send(1'b1, 16'd31);
    a_ready = 1'b0;
    in_sel = 1'b0;
    in_data = 16'd27;
    in_valid = 1'b1;
    qa.push_back(16'd27);
    @(negedge clk);
    check("bypass_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bypass_a_valid", {31'd0, a_valid}, 32'd1);
    check("bypass_a_data",  {16'd0, a_data},  32'd27);
    check("bypass_b_valid", {31'd0, b_valid}, 32'd1);
    check("bypass_b_data",  {16'd0, b_data},  32'd31);
    a_ready = 1'b1;
    b_ready = 1'b1;
    tick();
    tick();
    check("bypass_a_count", {24'd0, a_count}, 32'd2);
    check("bypass_b_count", {24'd0, b_count}, 32'd4);

    // Full-rate drain+load on A.
    for (int i = 1; i <= 4; i++) begin
      send(1'b0, 16'(i));
      check("rate_a_valid", {31'd0, a_valid}, 32'd1);
      check("rate_a_data",  {16'd0, a_data},  32'(i));
    end
    tick();
    check("rate_a_count", {24'd0, a_count}, 32'd6);
    check("rate_a_empty", {31'd0, a_valid}, 32'd0);

    // Counter wrap on A, B untouched.
    reset_pulse();
    tick();
    send(1'b1, 16'h0B0B);
    tick();
    tick();
    for (int i = 0; i < 255; i++) send(1'b0, 16'(i));
    tick();
    tick();
    check("wrap_a_count_max", {24'd0, a_count}, 32'd255);
    send(1'b0, 16'h0100);
    tick();
    tick();
    check("wrap_a_count_zero", {24'd0, a_count}, 32'd0);
    check("wrap_b_count", {24'd0, b_count}, 32'd1);
    check("wrap_a_empty", {31'd0, a_valid}, 32'd0);

    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux16_router.md
Name: demux16_router

Overview:
- Inverse of the 16-bit 2:1 datapath mux: takes one 16-bit source stream and steers each word to one of two destinations, A or B, chosen by a per-word select bit.
- Each destination has a one-entry registered output stage with a valid/ready handshake, so a stalled destination back-pressures the source.
- Used in the CPU datapath to fan ALU/load results out to two consumers, for example the register-file write port and the memory store path.

Parameters:
WIDTH, 16, data word width in bits
CNT_W, 8, width of the per-channel delivered-word counters

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source presents a word
in_ready  output  1  router can accept the presented word this cycle
in_data  input  WIDTH  source word
in_sel  input  1  destination select: 0 = channel A, 1 = channel B
a_valid  output  1  channel A holds a word
a_ready  input  1  channel A consumer takes the word
a_data  output  WIDTH  channel A word
b_valid  output  1  channel B holds a word
b_ready  input  1  channel B consumer takes the word
b_data  output  WIDTH  channel B word
a_count  output  CNT_W  words delivered on channel A
b_count  output  CNT_W  words delivered on channel B

Behaviour:
- Reset (asynchronous, rst_n=0): a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0. Takes effect immediately and overrides any handshake in progress. A word held at reset is discarded.
- After rst_n deasserts, operation starts on the first rising clk edge.
- Each channel X in {A, B} is a one-entry buffer: register x_valid plus register x_data.
- X_free = !x_valid || x_ready.
- in_ready is combinational: in_ready = in_sel ? B_free : A_free. It depends only on in_sel, the valid registers and the out ready inputs, never on in_valid.
- Source accept is acc = in_valid && in_ready. On acc, the selected channel loads in_data and sets its valid to 1 at the next edge.
- Latency: a word accepted at edge N appears on x_data with x_valid=1 after edge N. It is visible in the cycle following acceptance.
- Output handshake fires when x_valid && x_ready. At that edge:
  - if the channel is not being loaded, x_valid clears;
  - if it is being loaded in the same cycle (drain+load), x_valid stays 1 and x_data takes the new word.
  - Result: one word per cycle sustained throughput per channel with no bubble.
- x_data holds its value whenever the channel is not loaded. After a drain without reload it keeps the old value, but x_valid=0.
- x_valid never drops without the handshake, and x_data never changes while x_valid=1 and x_ready=0 (no overwrite of held data).
- Channel select per word:
  - The non-selected channel is unaffected by the source.
  - A stalled channel blocks only words directed at it. A word for the other channel passes if that channel is free.
  - No reordering within a channel.
- in_sel and in_data must be stable while in_valid=1 and in_ready=0. This is a source obligation and is not checked.
- Counters: x_count increments by 1 on each channel-X output handshake. It wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Both channels may handshake in the same cycle; both counters update independently.
- If in_valid=0, no channel loads regardless of in_sel.

Test Plan:
- Reset mid-operation: load A with 63 (a_valid=1, a_ready=0), then pulse rst_n=0 between edges -> a_valid=0, a_data=0, a_count=0 immediately, with no clk edge needed.
- Basic steering: send 63 with sel=0, then 24 with sel=1, ready high on both -> a_data=63 one cycle after its accept, b_data=24 one cycle after its accept, a_count=1, b_count=1.
- Back-pressure: b_ready=0, send 31 (sel=1) then 127 (sel=1) -> first accepted; in_ready=0 for second; b_data stays 31 until b_ready=1. Next edge: b_data=127, b_count=1. Following edge: b_count=2.
- Cross-channel bypass while stalled: B holding 31 with b_ready=0, send 27 with sel=0 -> in_ready=1, a_data=27 next cycle, B unchanged.
- Full-rate drain+load: a_ready=1, in_valid=1, sel=0 for 4 cycles with data 1,2,3,4 -> a_valid stays 1 throughout, a_data sequence 1,2,3,4 on consecutive cycles, a_count=4.
- Counter wrap: deliver 256 words on A -> a_count returns to 0, b_count unchanged.
